// File: rtl/vx_gpu_pkg.sv
// rtl/vx_gpu_pkg.sv - shared sizing helpers for the request tag arbiter
package vx_gpu_pkg;

    localparam int MAX_NUM_REQS = 16;

    // Index field width inserted into the tag; zero for a single requester.
    function automatic int log_num_reqs(input int n);
        return (n > 1) ? $clog2((n > MAX_NUM_REQS) ? MAX_NUM_REQS : n) : 0;
    endfunction

    function automatic int tag_out_width(input int tag_w, input int n);
        return tag_w + log_num_reqs(n);
    endfunction

    // Storage width for an index register; never zero so the logic stays legal at NUM_REQS=1.
    function automatic int idx_width(input int n);
        return (n > 1) ? log_num_reqs(n) : 1;
    endfunction

endpackage

// File: rtl/vx_req_tag_rr.sv
// rtl/vx_req_tag_rr.sv - round-robin grant with priority pointer and stall lock
module vx_req_tag_rr
    import vx_gpu_pkg::*;
#(
    parameter int  NUM_REQS = 4,
    localparam int IDX_W    = idx_width(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] valid,
    input  logic                stage_ready,
    output logic [NUM_REQS-1:0] grant_onehot,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             locked;
    logic [IDX_W-1:0] search_idx;
    logic             search_found;
    logic [IDX_W-1:0] next_ptr;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        int k;
        k            = 0;
        search_idx   = '0;
        search_found = 1'b0;
        for (int off = 0; off < NUM_REQS; off++) begin
            k = int'(rr_ptr) + off;
            if (k >= NUM_REQS) k = k - NUM_REQS;
            if (!search_found && valid[k]) begin
                search_found = 1'b1;
                search_idx   = IDX_W'(k);
            end
        end
    end

    // A stalled grant stays put until accepted, whatever else becomes valid.
    always_comb begin
        grant_idx    = locked ? lock_idx : search_idx;
        grant_valid  = locked ? valid[lock_idx] : search_found;
        grant_onehot = '0;
        if (grant_valid) grant_onehot[grant_idx] = 1'b1;
        next_ptr     = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
    end

    // Pointer moves only on acceptance; lock tracks an offered-but-refused grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else begin
            locked   <= grant_valid && !stage_ready;
            lock_idx <= grant_idx;
            if (grant_valid && stage_ready)
                rr_ptr <= (NUM_REQS > 1) ? next_ptr : '0;
        end
    end

endmodule

// File: rtl/vx_req_tag_arb.sv
// rtl/vx_req_tag_arb.sv - round-robin request arbiter with index-tagged response routing (optional output buffer: REQ_TAG_ARB_OUT_BUF_EN)
module vx_req_tag_arb
    import vx_gpu_pkg::*;
#(
    parameter int  NUM_REQS      = 4,
    parameter int  DATA_WIDTH    = 32,
    parameter int  TAG_WIDTH     = 8,
    parameter int  TAG_SEL_POS   = 0,
    localparam int LOG_NUM_REQS  = log_num_reqs(NUM_REQS),
    localparam int TAG_OUT_WIDTH = tag_out_width(TAG_WIDTH, NUM_REQS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQS-1:0]                  req_valid_in,
    input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  req_data_in,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag_in,
    output logic [NUM_REQS-1:0]                  req_ready_in,
    output logic                                 req_valid_out,
    output logic [DATA_WIDTH-1:0]                req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]             req_tag_out,
    input  logic                                 req_ready_out,
    input  logic                                 rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]                rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]             rsp_tag_in,
    output logic                                 rsp_ready_in,
    output logic [NUM_REQS-1:0]                  rsp_valid_out,
    output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  rsp_data_out,
    output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   rsp_tag_out,
    input  logic [NUM_REQS-1:0]                  rsp_ready_out
);

    localparam int IDX_W = idx_width(NUM_REQS);

    logic [NUM_REQS-1:0]      grant_onehot;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_valid;
    logic                     stage_valid;
    logic                     stage_ready;
    logic [DATA_WIDTH-1:0]    stage_data;
    logic [TAG_WIDTH-1:0]     granted_tag;
    logic [TAG_OUT_WIDTH-1:0] stage_tag;
    logic [IDX_W-1:0]         rsp_idx;
    logic [TAG_WIDTH-1:0]     rsp_tag_strip;

    vx_req_tag_rr #(
        .NUM_REQS (NUM_REQS)
    ) u_rr (
        .clk          (clk),
        .reset        (reset),
        .valid        (req_valid_in),
        .stage_ready  (stage_ready),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    assign stage_valid  = grant_valid && !reset;
    assign stage_data   = req_data_in[grant_idx];
    assign granted_tag  = req_tag_in[grant_idx];
    assign req_ready_in = grant_onehot & {NUM_REQS{stage_ready && !reset}};

    // Splice the grant index into the tag at TAG_SEL_POS.
    always_comb begin
        stage_tag = '0;
        for (int i = 0; i < TAG_OUT_WIDTH; i++) begin
            if (i < TAG_SEL_POS)
                stage_tag[i] = granted_tag[i];
            else if (i < TAG_SEL_POS + LOG_NUM_REQS)
                stage_tag[i] = grant_idx[i - TAG_SEL_POS];
            else
                stage_tag[i] = granted_tag[i - LOG_NUM_REQS];
        end
    end

`ifdef REQ_TAG_ARB_OUT_BUF_EN
    logic [DATA_WIDTH-1:0]    buf_data [2];
    logic [TAG_OUT_WIDTH-1:0] buf_tag  [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic                     push;
    logic                     pop;

    // Ready comes from occupancy only, so the downstream ready never reaches requesters.
    assign stage_ready   = (count != 2'd2);
    assign push          = stage_valid && stage_ready;
    assign pop           = req_valid_out && req_ready_out;
    assign req_valid_out = (count != 2'd0) && !reset;
    assign req_data_out  = buf_data[rd_ptr];
    assign req_tag_out   = buf_tag[rd_ptr];

    // Two-entry skid store; reset drops anything held.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= stage_data;
                buf_tag[wr_ptr]  <= stage_tag;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
`else
    assign stage_ready   = req_ready_out;
    assign req_valid_out = stage_valid;
    assign req_data_out  = stage_data;
    assign req_tag_out   = stage_tag;
`endif

    // Extract the index field and rejoin the tag bits around it.
    always_comb begin
        rsp_idx       = '0;
        rsp_tag_strip = '0;
        for (int i = 0; i < LOG_NUM_REQS; i++)
            rsp_idx[i] = rsp_tag_in[TAG_SEL_POS + i];
        for (int i = 0; i < TAG_WIDTH; i++)
            rsp_tag_strip[i] = (i < TAG_SEL_POS) ? rsp_tag_in[i] : rsp_tag_in[i + LOG_NUM_REQS];
    end

    // Zero-latency routing; an out-of-range index is swallowed.
    always_comb begin
        rsp_valid_out = '0;
        rsp_ready_in  = 1'b1;
        for (int r = 0; r < NUM_REQS; r++) begin
            rsp_data_out[r] = rsp_data_in;
            rsp_tag_out[r]  = rsp_tag_strip;
            if (int'(rsp_idx) == r) begin
                rsp_valid_out[r] = rsp_valid_in;
                rsp_ready_in     = rsp_ready_out[r];
            end
        end
    end

endmodule

// File: tb/tb_vx_req_tag_arb.sv
// tb/tb_vx_req_tag_arb.sv - directed bench for vx_req_tag_arb (REQ_TAG_ARB_OUT_BUF_EN selects latency)
module tb_vx_req_tag_arb;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int TOW = 10;
`ifdef REQ_TAG_ARB_OUT_BUF_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [N-1:0]           req_valid_in;
    logic [N-1:0][DW-1:0]   req_data_in;
    logic [N-1:0][TW-1:0]   req_tag_in;
    logic                   req_ready_out;
    logic                   rsp_valid_in;
    logic [DW-1:0]          rsp_data_in;
    logic [TOW-1:0]         rsp_tag_in;
    logic [N-1:0]           rsp_ready_out;

    logic [N-1:0]           rdy_in0, rdy_in4;
    logic                   vout0, vout4;
    logic [DW-1:0]          dout0, dout4;
    logic [TOW-1:0]         tout0, tout4;
    logic                   rsp_rdy0, rsp_rdy4;
    logic [N-1:0]           rvo0, rvo4;
    logic [N-1:0][DW-1:0]   rdo0, rdo4;
    logic [N-1:0][TW-1:0]   rto0, rto4;

    logic [2:0]             n3_valid;
    logic [2:0][DW-1:0]     n3_data;
    logic [2:0][TW-1:0]     n3_tag;
    logic [2:0]             n3_rdy_in;
    logic                   n3_vout;
    logic [DW-1:0]          n3_dout;
    logic [TOW-1:0]         n3_tout;
    logic                   n3_rsp_valid;
    logic [TOW-1:0]         n3_rsp_tag;
    logic [2:0]             n3_rsp_ready_out;
    logic                   n3_rsp_rdy;
    logic [2:0]             n3_rvo;
    logic [2:0][DW-1:0]     n3_rdo;
    logic [2:0][TW-1:0]     n3_rto;

    vx_req_tag_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TAG_SEL_POS(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_in(rdy_in0), .req_valid_out(vout0), .req_data_out(dout0), .req_tag_out(tout0),
        .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
        .rsp_ready_in(rsp_rdy0), .rsp_valid_out(rvo0), .rsp_data_out(rdo0), .rsp_tag_out(rto0),
        .rsp_ready_out(rsp_ready_out)
    );

    vx_req_tag_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TAG_SEL_POS(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_in(rdy_in4), .req_valid_out(vout4), .req_data_out(dout4), .req_tag_out(tout4),
        .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
        .rsp_ready_in(rsp_rdy4), .rsp_valid_out(rvo4), .rsp_data_out(rdo4), .rsp_tag_out(rto4),
        .rsp_ready_out(rsp_ready_out)
    );

    vx_req_tag_arb #(.NUM_REQS(3), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TAG_SEL_POS(0)) dut_n3 (
        .clk(clk), .reset(reset),
        .req_valid_in(n3_valid), .req_data_in(n3_data), .req_tag_in(n3_tag),
        .req_ready_in(n3_rdy_in), .req_valid_out(n3_vout), .req_data_out(n3_dout), .req_tag_out(n3_tout),
        .req_ready_out(1'b0),
        .rsp_valid_in(n3_rsp_valid), .rsp_data_in(rsp_data_in), .rsp_tag_in(n3_rsp_tag),
        .rsp_ready_in(n3_rsp_rdy), .rsp_valid_out(n3_rvo), .rsp_data_out(n3_rdo), .rsp_tag_out(n3_rto),
        .rsp_ready_out(n3_rsp_ready_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int             out_idx_q[$];
    logic [TOW-1:0] out_t0_q[$];
    logic [TOW-1:0] out_t4_q[$];
    logic [DW-1:0]  out_d_q[$];
    int             out_cyc_q[$];
    int             in_cyc_q[$];
    int             ptr_q[$];
    bit             auto_drop = 1'b1;
    bit             ptr_pend  = 1'b0;
    logic [N-1:0]   drop_mask;

    typedef struct {
        int             idx;
        logic [TW-1:0]  tag;
        logic [TOW-1:0] e0;
        logic [TOW-1:0] e4;
    } tag_vec_t;

    typedef struct {
        logic           v;
        logic [TOW-1:0] tag;
        logic [N-1:0]   rdy;
        int             ix0;
        logic [N-1:0]   ev0;
        logic [TW-1:0]  et0;
        logic           er0;
        int             ix4;
        logic [N-1:0]   ev4;
        logic [TW-1:0]  et4;
        logic           er4;
    } rsp_vec_t;

    tag_vec_t tv[4];
    rsp_vec_t rv[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        out_idx_q.delete(); out_t0_q.delete(); out_t4_q.delete(); out_d_q.delete();
        out_cyc_q.delete(); in_cyc_q.delete(); ptr_q.delete();
        ptr_pend = 1'b0;
    endtask

    task automatic sample();
        #1;
        if (ptr_pend) ptr_q.push_back(int'(dut0.u_rr.rr_ptr));
        ptr_pend = ((rdy_in0 & req_valid_in) != '0);
        if (vout0 && req_ready_out) begin
            out_idx_q.push_back(int'(tout0[1:0]));
            out_t0_q.push_back(tout0);
            out_t4_q.push_back(tout4);
            out_d_q.push_back(dout0);
            out_cyc_q.push_back(cyc);
        end
        if ((rdy_in0 & req_valid_in) != '0) in_cyc_q.push_back(cyc);
        drop_mask = auto_drop ? (rdy_in0 & req_valid_in) : '0;
    endtask

    task automatic next_cyc();
        @(negedge clk);
        cyc++;
        req_valid_in = req_valid_in & ~drop_mask;
    endtask

    task automatic step();
        sample();
        next_cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{1, 8'h5A, 10'h169, 10'h15A};
        tv[1] = '{3, 8'hFF, 10'h3FF, 10'h3FF};
        tv[2] = '{0, 8'h81, 10'h204, 10'h201};
        tv[3] = '{2, 8'h3C, 10'h0F2, 10'h0EC};

        rv[0] = '{1'b1, 10'h2A7, 4'b1111, 3, 4'b1000, 8'hA9, 1'b1, 2, 4'b0100, 8'hA7, 1'b1};
        rv[1] = '{1'b1, 10'h2A7, 4'b0111, 3, 4'b1000, 8'hA9, 1'b0, 2, 4'b0100, 8'hA7, 1'b1};
        rv[2] = '{1'b1, 10'h155, 4'b0010, 1, 4'b0010, 8'h55, 1'b1, 1, 4'b0010, 8'h55, 1'b1};
        rv[3] = '{1'b1, 10'h000, 4'b1110, 0, 4'b0001, 8'h00, 1'b0, 0, 4'b0001, 8'h00, 1'b0};
        rv[4] = '{1'b0, 10'h2A7, 4'b1111, 3, 4'b0000, 8'hA9, 1'b1, 2, 4'b0000, 8'hA7, 1'b1};

        reset = 1'b1; req_valid_in = '1; req_ready_out = 1'b1; drop_mask = '0;
        for (int i = 0; i < N; i++) begin
            req_data_in[i] = DW'(i); req_tag_in[i] = TW'(i);
        end
        rsp_valid_in = 1'b0; rsp_data_in = '0; rsp_tag_in = '0; rsp_ready_out = '0;
        n3_valid = '0; n3_data = '0; n3_tag = '0;
        n3_rsp_valid = 1'b0; n3_rsp_tag = '0; n3_rsp_ready_out = '0;

        // reset cycle with every requester pushing
        sample();
        chk("rst_valid_out", vout0, 1'b0);
        chk("rst_ready_in", rdy_in0, 4'b0000);
        chk("rst_valid_out_pos4", vout4, 1'b0);
        chk("rst_ready_in_pos4", rdy_in4, 4'b0000);
        next_cyc();
        reset = 1'b0; req_valid_in = '0;
        step();

        // tag insertion table, one requester at a time
        for (int r = 0; r < 4; r++) begin
            clear_q();
            req_tag_in[tv[r].idx]  = tv[r].tag;
            req_data_in[tv[r].idx] = 32'hD000_0000 + DW'(r);
            req_valid_in = '0;
            req_valid_in[tv[r].idx] = 1'b1;
            req_ready_out = 1'b1;
            for (int w = 0; w < 6 && out_t0_q.size() == 0; w++) step();
            chk($sformatf("tag_out_seen_%0d", r), out_t0_q.size(), 1);
            if (out_t0_q.size() > 0) begin
                chk($sformatf("tag_pos0_%0d", r), out_t0_q[0], tv[r].e0);
                chk($sformatf("tag_pos4_%0d", r), out_t4_q[0], tv[r].e4);
                chk($sformatf("data_%0d", r), out_d_q[0], 32'hD000_0000 + DW'(r));
                if (r == 0 && in_cyc_q.size() > 0)
                    chk("out_latency", out_cyc_q[0] - in_cyc_q[0], LAT);
            end
            step(); step();
        end

        // round robin with everyone valid and the sink always ready
        reset = 1'b1; req_valid_in = '0; step(); reset = 1'b0;
        clear_q();
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++) req_tag_in[i] = TW'(8'h11 * i);
        req_valid_in = '1; req_ready_out = 1'b1;
        repeat (5 + LAT) step();
        req_valid_in = '0; auto_drop = 1'b1;
        step(); step();
        chk("rr_count_ge5", out_idx_q.size() >= 5, 1'b1);
        if (out_idx_q.size() >= 5) begin
            for (int k = 0; k < 5; k++)
                chk($sformatf("rr_grant_%0d", k), out_idx_q[k], k % N);
            chk("rr_back_to_back", out_cyc_q[4] - out_cyc_q[0], 4);
        end

        // stall on req2 while req0 shows up
        reset = 1'b1; req_valid_in = '0; step(); reset = 1'b0;
        clear_q();
        req_tag_in[2] = 8'h22; req_data_in[2] = 32'h2222_0000;
        req_tag_in[0] = 8'h33; req_data_in[0] = 32'h3333_0000;
        req_valid_in = 4'b0100; req_ready_out = 1'b0;
        step();
        for (int s = 0; s < 3; s++) begin
            if (s == 0) req_valid_in[0] = 1'b1;
            sample();
            chk($sformatf("stall_valid_%0d", s), vout0, 1'b1);
            chk($sformatf("stall_tag_%0d", s), tout0, 10'h08A);
            chk($sformatf("stall_data_%0d", s), dout0, 32'h2222_0000);
            next_cyc();
        end
        req_ready_out = 1'b1;
        for (int w = 0; w < 8 && out_idx_q.size() < 2; w++) step();
        req_valid_in = '0;
        step(); step();
        chk("stall_out_count", out_idx_q.size(), 2);
        if (out_idx_q.size() >= 2) begin
            chk("stall_first_req2", out_idx_q[0], 2);
            chk("stall_then_req0", out_idx_q[1], 0);
        end
        chk("stall_ptr_samples", ptr_q.size(), 2);
        if (ptr_q.size() >= 2) begin
            chk("ptr_after_req2", ptr_q[0], 3);
            chk("ptr_after_req0", ptr_q[1], 1);
        end

        // reset while req1 is stalled
        clear_q();
        req_tag_in[1] = 8'h77; req_tag_in[0] = 8'h44;
        req_valid_in = 4'b0010; req_ready_out = 1'b0;
        step(); step();
        reset = 1'b1;
        sample();
        chk("midrst_valid_out", vout0, 1'b0);
        chk("midrst_ready_in", rdy_in0, 4'b0000);
        next_cyc();
        reset = 1'b0; req_valid_in = '0;
        sample();
        chk("postrst_valid_out", vout0, 1'b0);
        chk("postrst_rr_ptr", dut0.u_rr.rr_ptr, 2'd0);
        next_cyc();
        clear_q();
        req_valid_in = 4'b0011; req_ready_out = 1'b1;
        for (int w = 0; w < 8 && out_idx_q.size() < 2; w++) step();
        req_valid_in = '0;
        step(); step();
        chk("postrst_out_count", out_idx_q.size(), 2);
        if (out_idx_q.size() >= 2) begin
            chk("postrst_first_req0", out_idx_q[0], 0);
            chk("postrst_first_tag", out_t0_q[0], 10'h110);
            chk("postrst_then_req1", out_idx_q[1], 1);
        end

        // response routing table
        for (int r = 0; r < 5; r++) begin
            rsp_valid_in  = rv[r].v;
            rsp_tag_in    = rv[r].tag;
            rsp_ready_out = rv[r].rdy;
            rsp_data_in   = 32'hCAFE_0000 + DW'(r);
            sample();
            chk($sformatf("rsp_valid_p0_%0d", r), rvo0, rv[r].ev0);
            chk($sformatf("rsp_tag_p0_%0d", r), rto0[rv[r].ix0], rv[r].et0);
            chk($sformatf("rsp_ready_p0_%0d", r), rsp_rdy0, rv[r].er0);
            chk($sformatf("rsp_data_p0_%0d", r), rdo0[rv[r].ix0], 32'hCAFE_0000 + DW'(r));
            chk($sformatf("rsp_valid_p4_%0d", r), rvo4, rv[r].ev4);
            chk($sformatf("rsp_tag_p4_%0d", r), rto4[rv[r].ix4], rv[r].et4);
            chk($sformatf("rsp_ready_p4_%0d", r), rsp_rdy4, rv[r].er4);
            chk($sformatf("rsp_data_p4_%0d", r), rdo4[rv[r].ix4], 32'hCAFE_0000 + DW'(r));
            next_cyc();
        end

        // three requesters: index 3 is out of range and swallowed
        n3_rsp_valid = 1'b1; n3_rsp_tag = 10'h2A7; n3_rsp_ready_out = 3'b000;
        sample();
        chk("n3_oob_valid", n3_rvo, 3'b000);
        chk("n3_oob_ready", n3_rsp_rdy, 1'b1);
        next_cyc();
        n3_rsp_tag = 10'h2A6;
        sample();
        chk("n3_idx2_valid", n3_rvo, 3'b100);
        chk("n3_idx2_ready", n3_rsp_rdy, 1'b0);
        chk("n3_idx2_tag", n3_rto[2], 8'hA9);
        next_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
